// File: rtl/literal_decode_stage.sv
// Literal-bus decode stage: integrity check, 2-entry FIFO and one-hot decode of the {a1,a0,~a1,~a0} bus.
// Define ERR_COUNT_EN to build the ERR_W-bit saturating malformed-word counter on err_count.
module literal_decode_stage #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       lit_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       code_out,
    output logic [3:0]       dec_out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic             lit_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // A word is well-formed when its complement half is the exact inverse of its true half.
    function automatic logic word_good(input logic [3:0] w);
        return (w[1:0] == ~w[3:2]);
    endfunction

    logic [1:0] count_q, count_d;
    logic [1:0] head_q, head_d;
    logic [1:0] tail_q, tail_d;
    logic [1:0] code_q, code_d;
    logic [3:0] dec_q, dec_d;
    logic       valid_q, valid_d;
    logic       lit_err_q, lit_err_d;
    logic       in_ready_s, accept_s, push_s, bad_s, pop_s;
    logic [1:0] in_code_s;

    // Handshake decode; in_ready depends only on the count register, never on out_ready.
    always_comb begin
        in_ready_s = ~rst & (count_q != ST_FULL);
        accept_s   = in_valid & in_ready_s;
        push_s     = accept_s & word_good(lit_in);
        bad_s      = accept_s & ~word_good(lit_in);
        pop_s      = valid_q & out_ready;
        in_code_s  = lit_in[3:2];
    end

    // Occupancy FSM and FIFO storage update.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            ST_EMPTY: begin
                if (push_s) begin
                    head_d  = in_code_s;
                    count_d = ST_ONE;
                end else begin
                    count_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (push_s && pop_s) begin
                    head_d  = in_code_s;
                    count_d = ST_ONE;
                end else if (push_s) begin
                    tail_d  = in_code_s;
                    count_d = ST_FULL;
                end else if (pop_s) begin
                    count_d = ST_EMPTY;
                end else begin
                    count_d = ST_ONE;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    head_d  = tail_q;
                    count_d = ST_ONE;
                end else begin
                    count_d = ST_FULL;
                end
            end
            default: begin
                count_d = ST_EMPTY;
            end
        endcase
    end

    // Output registers track the next head so data appears one cycle after accept and blanks when empty.
    always_comb begin
        valid_d = (count_d != ST_EMPTY);
        if (valid_d) begin
            code_d = head_d;
            dec_d  = 4'b0001 << head_d;
        end else begin
            code_d = 2'b00;
            dec_d  = 4'b0000;
        end
    end

    // Sticky error flag: a malformed accept on the same edge as a clear wins.
    always_comb begin
        if (bad_s) begin
            lit_err_d = 1'b1;
        end else if (clr_err) begin
            lit_err_d = 1'b0;
        end else begin
            lit_err_d = lit_err_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= ST_EMPTY;
            head_q    <= 2'b00;
            tail_q    <= 2'b00;
            code_q    <= 2'b00;
            dec_q     <= 4'b0000;
            valid_q   <= 1'b0;
            lit_err_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            code_q    <= code_d;
            dec_q     <= dec_d;
            valid_q   <= valid_d;
            lit_err_q <= lit_err_d;
        end
    end

`ifdef ERR_COUNT_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating malformed-word counter; clear plus a bad word on one edge restarts at one.
    always_comb begin
        if (bad_s && clr_err) begin
            err_cnt_d = {{(ERR_W-1){1'b0}}, 1'b1};
        end else if (bad_s) begin
            if (err_cnt_q == {ERR_W{1'b1}}) begin
                err_cnt_d = err_cnt_q;
            end else begin
                err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
            end
        end else if (clr_err) begin
            err_cnt_d = {ERR_W{1'b0}};
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= {ERR_W{1'b0}};
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = {ERR_W{1'b0}};
`endif

    assign in_ready  = in_ready_s;
    assign code_out  = code_q;
    assign dec_out   = dec_q;
    assign out_valid = valid_q;
    assign lit_err   = lit_err_q;

endmodule

// File: tb/tb_literal_decode_stage.sv
// Directed self-checking bench for literal_decode_stage (ERR_W=2; err_count expectations follow ERR_COUNT_EN).
module tb_literal_decode_stage;

    logic       clk;
    logic       rst;
    logic [3:0] lit_in;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] code_out;
    logic [3:0] dec_out;
    logic       out_valid;
    logic       out_ready;
    logic       clr_err;
    logic       lit_err;
    logic [1:0] err_count;

    int checks = 0;
    int errors = 0;

`ifdef ERR_COUNT_EN
    localparam logic [7:0] EXP_CNT_ONE = 8'd1;
    localparam logic [7:0] EXP_CNT_SAT = 8'd3;
`else
    localparam logic [7:0] EXP_CNT_ONE = 8'd0;
    localparam logic [7:0] EXP_CNT_SAT = 8'd0;
`endif

    literal_decode_stage #(.ERR_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .lit_in    (lit_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code_out  (code_out),
        .dec_out   (dec_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clr_err   (clr_err),
        .lit_err   (lit_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; lit_in = 4'b0000; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
        #3;
        chk("rst_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_code", {6'd0, code_out}, 8'd0);
        chk("rst_dec", {4'd0, dec_out}, 8'd0);
        chk("rst_err", {7'd0, lit_err}, 8'd0);
        chk("rst_cnt", {6'd0, err_count}, 8'd0);
        chk("rst_ready", {7'd0, in_ready}, 8'd0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("rel_ready", {7'd0, in_ready}, 8'd1);

        // single good word
        out_ready = 1'b1; lit_in = 4'b1001; in_valid = 1'b1;
        step();
        chk("good_valid", {7'd0, out_valid}, 8'd1);
        chk("good_code", {6'd0, code_out}, 8'h2);
        chk("good_dec", {4'd0, dec_out}, 8'h4);
        in_valid = 1'b0;
        step();
        chk("good_drain", {7'd0, out_valid}, 8'd0);
        chk("good_dec0", {4'd0, dec_out}, 8'h0);

        // malformed word then clear
        lit_in = 4'b1111; in_valid = 1'b1;
        step();
        chk("bad_err", {7'd0, lit_err}, 8'd1);
        chk("bad_valid", {7'd0, out_valid}, 8'd0);
        chk("bad_ready", {7'd0, in_ready}, 8'd1);
        chk("bad_cnt", {6'd0, err_count}, EXP_CNT_ONE);
        in_valid = 1'b0; clr_err = 1'b1;
        step();
        chk("clr_err", {7'd0, lit_err}, 8'd0);
        chk("clr_cnt", {6'd0, err_count}, 8'd0);
        clr_err = 1'b0;

        // backpressure
        out_ready = 1'b0; lit_in = 4'b0011; in_valid = 1'b1;
        step();
        chk("bp1_code", {6'd0, code_out}, 8'h0);
        chk("bp1_dec", {4'd0, dec_out}, 8'h1);
        chk("bp1_ready", {7'd0, in_ready}, 8'd1);
        lit_in = 4'b0110;
        step();
        chk("bp2_ready", {7'd0, in_ready}, 8'd0);
        lit_in = 4'b1100;
        step();
        chk("bp3_ready", {7'd0, in_ready}, 8'd0);
        chk("bp3_hold", {6'd0, code_out}, 8'h0);
        out_ready = 1'b1;
        step();
        chk("bp_pop1_code", {6'd0, code_out}, 8'h1);
        chk("bp_pop1_dec", {4'd0, dec_out}, 8'h2);
        chk("bp_pop1_ready", {7'd0, in_ready}, 8'd1);
        step();
        chk("bp_pop2_code", {6'd0, code_out}, 8'h3);
        chk("bp_pop2_dec", {4'd0, dec_out}, 8'h8);
        in_valid = 1'b0;
        step();
        chk("bp_empty", {7'd0, out_valid}, 8'd0);

        // simultaneous push/pop with one entry
        out_ready = 1'b0; lit_in = 4'b0110; in_valid = 1'b1;
        step();
        chk("pp_head", {6'd0, code_out}, 8'h1);
        out_ready = 1'b1; lit_in = 4'b1001;
        step();
        chk("pp_code", {6'd0, code_out}, 8'h2);
        chk("pp_valid", {7'd0, out_valid}, 8'd1);
        chk("pp_ready", {7'd0, in_ready}, 8'd1);
        in_valid = 1'b0;
        step();
        chk("pp_empty", {7'd0, out_valid}, 8'd0);

        // saturating counter and clear-vs-set priority
        lit_in = 4'b0000; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        chk("sat_cnt", {6'd0, err_count}, EXP_CNT_SAT);
        chk("sat_valid", {7'd0, out_valid}, 8'd0);
        clr_err = 1'b1;
        step();
        chk("setwin_cnt", {6'd0, err_count}, EXP_CNT_ONE);
        chk("setwin_err", {7'd0, lit_err}, 8'd1);
        clr_err = 1'b0; in_valid = 1'b0;

        // reset mid-stream with a full FIFO
        out_ready = 1'b0; lit_in = 4'b0011; in_valid = 1'b1;
        step();
        lit_in = 4'b0110;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_valid", {7'd0, out_valid}, 8'd0);
        chk("mrst_dec", {4'd0, dec_out}, 8'h0);
        chk("mrst_err", {7'd0, lit_err}, 8'd0);
        chk("mrst_ready", {7'd0, in_ready}, 8'd0);
        step(); step();
        rst = 1'b0; out_ready = 1'b1;
        step();
        chk("mrst_nostale", {7'd0, out_valid}, 8'd0);
        lit_in = 4'b1001; in_valid = 1'b1;
        step();
        chk("mrst_first", {6'd0, code_out}, 8'h2);
        in_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/literal_decode_stage.md
Name: literal_decode_stage

Overview:
- Downstream consumer of the 2-bit true/complement literal generator. Takes its 4-bit literal bus {a[1], a[0], ~a[1], ~a[0]} through a valid/ready handshake.
- Checks each word's complement integrity, buffers good words in a 2-entry FIFO, and presents them as a 2-bit code plus a one-hot 4-bit decode.
- Drops malformed words and raises a sticky error flag.

Parameters:
- ERR_W, 8, width of the saturating malformed-word counter (used only when ERR_COUNT_EN is defined).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- lit_in  input  4  literal bus. [3]=a1, [2]=a0, [1]=~a1, [0]=~a0.
- in_valid  input  1  lit_in is valid this cycle.
- in_ready  output  1  stage can accept a word this cycle.
- code_out  output  2  decoded code {a1,a0} of the head entry.
- dec_out  output  4  one-hot of code_out; bit n set when code_out == n.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes the head entry this cycle.
- clr_err  input  1  synchronous clear of lit_err and err_count.
- lit_err  output  1  sticky: a malformed word was accepted.
- err_count  output  ERR_W  saturating count of malformed words. Driven 0 without ERR_COUNT_EN.

Behaviour:
- Reset (async, rst=1): FIFO empty and count=0. Outputs: out_valid=0, code_out=2'b00, dec_out=4'b0000, lit_err=0, err_count=0, in_ready=0 while rst is high.
- Accept: occurs when in_valid & in_ready are high at a clk edge.
- in_ready = (count != 2) and is registered-derived. There is no combinational path from out_ready to in_ready.
- Integrity: a word is good iff lit_in[1:0] == ~lit_in[3:2]. Its code is lit_in[3:2].
- Good accepted word: pushed to the FIFO.
- Malformed accepted word:
  - Not pushed.
  - lit_err is set next cycle.
  - err_count is incremented. It saturates at 2^ERR_W-1 and does not wrap.
  - Malformed words are accepted whenever in_ready=1, even if the FIFO is otherwise idle.
- Pop: occurs when out_valid & out_ready.
- Count FSM states:
  - EMPTY (0): push → ONE.
  - ONE (1):
    - push without pop → FULL.
    - pop without push → EMPTY.
    - push with pop → ONE. The new word becomes the head next cycle.
  - FULL (2): pop → ONE. A push is impossible because in_ready=0.
- Latency: a good word accepted at edge N is on code_out/dec_out with out_valid=1 after edge N (1 cycle). This holds if the FIFO was empty.
- Order is strictly FIFO. code_out/dec_out are held stable while out_valid & !out_ready.
- Output registers when out_valid=0: code_out=00, dec_out=0000. Stale data is not shown.
- dec_out is exactly one-hot when out_valid=1 and all zeros otherwise.
- clr_err=1 at an edge clears lit_err and err_count. If a malformed word is accepted on the same edge, the set wins: lit_err=1 and err_count=1.
- Reset mid-operation: all FIFO contents and pending words are discarded immediately (async). After release, the first accept is at the first edge where rst=0 and in_ready=1.

Optional Feature:
- Macro: ERR_COUNT_EN.
- Defined: the ERR_W-bit saturating counter is built and drives err_count, as above.
- Undefined:
  - No counter logic is built.
  - err_count is tied to 0.
  - lit_err behaviour is unchanged.
  - The port list is identical in both builds.

Test Plan:
- Reset: assert rst for 2 cycles mid-stream → out_valid=0, dec_out=0000, lit_err=0 immediately. No stale entry appears after release.
- Good word: out_ready=1, lit_in=4'b1001 (a=2'b10) with in_valid for 1 cycle → next cycle out_valid=1, code_out=2'b10, dec_out=4'b0100. Following cycle out_valid=0.
- Malformed word: lit_in=4'b1111 with in_valid → in_ready stays 1, out_valid stays 0, lit_err=1 next cycle. Then clr_err pulse → lit_err=0.
- Backpressure: out_ready=0, offer 4'b0011, 4'b0110, 4'b1100 back-to-back → first two accepted, in_ready=0 thereafter, third held. Raise out_ready → outputs codes 00, 01, 11 in order with dec_out 0001, 0010, 1000.
- Simultaneous push/pop at ONE: head code 01 with out_ready=1, push 4'b1001 → count stays 1, next head code 10.
- ERR_COUNT_EN with ERR_W=2: 5 malformed words (4'b0000) → err_count=3 (saturated). clr_err coincident with a 6th malformed word → err_count=1. Without the macro, err_count=0 throughout.
